// File: rtl/stream_dot_accumulator.sv
// Streaming signed multiply-accumulate: one operand pair per valid cycle,
// one dot product per NUM_BANDS accepted pairs, no backpressure.
module stream_dot_accumulator #(
    parameter int DATA_WIDTH   = 16,
    parameter int ACC_WIDTH    = 48,
    parameter int NUM_BANDS    = 8,
    parameter int MULT_LATENCY = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    input  logic signed [DATA_WIDTH-1:0] in_a,
    input  logic signed [DATA_WIDTH-1:0] in_b,
    output logic                         out_valid,
    output logic signed [ACC_WIDTH-1:0]  out_data,
    output logic                         busy
);

    localparam int PROD_W = 2 * DATA_WIDTH;
    localparam int CNT_W  = (NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1;
    localparam logic [CNT_W-1:0] LAST_BAND = CNT_W'(NUM_BANDS - 1);

    if (ACC_WIDTH < PROD_W + $clog2(NUM_BANDS)) begin : g_acc_width_chk
        $error("ACC_WIDTH too small for DATA_WIDTH and NUM_BANDS");
    end
    if (NUM_BANDS < 1) begin : g_bands_chk
        $error("NUM_BANDS must be at least 1");
    end
    if (MULT_LATENCY < 1) begin : g_lat_chk
        $error("MULT_LATENCY must be at least 1");
    end

    logic [CNT_W-1:0] band_cnt_q, band_cnt_d;
    logic             is_first, is_last;

    logic signed [PROD_W-1:0] a_ext, b_ext, mul;

    logic signed [PROD_W-1:0] prod_q [MULT_LATENCY];
    logic [MULT_LATENCY-1:0]  vld_q, first_q, last_q;

    logic signed [ACC_WIDTH-1:0] p_ext, sum;
    logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
    logic signed [ACC_WIDTH-1:0] out_data_q, out_data_d;
    logic                        out_valid_q, out_valid_d;

    assign is_first = (band_cnt_q == '0);
    assign is_last  = (band_cnt_q == LAST_BAND);

    always_comb begin
        band_cnt_d = band_cnt_q;
        if (in_valid) begin
            band_cnt_d = is_last ? '0 : band_cnt_q + 1'b1;
        end
    end

    // Operands widened first so the multiply is evaluated at full product width.
    assign a_ext = in_a;
    assign b_ext = in_b;
    assign mul   = a_ext * b_ext;

    always_ff @(posedge clk) begin
        if (rst) begin
            band_cnt_q <= '0;
            vld_q      <= '0;
            first_q    <= '0;
            last_q     <= '0;
            for (int unsigned i = 0; i < MULT_LATENCY; i++) begin
                prod_q[i] <= '0;
            end
        end else begin
            band_cnt_q <= band_cnt_d;
            vld_q[0]   <= in_valid;
            first_q[0] <= in_valid & is_first;
            last_q[0]  <= in_valid & is_last;
            prod_q[0]  <= mul;
            for (int unsigned i = 1; i < MULT_LATENCY; i++) begin
                vld_q[i]   <= vld_q[i-1];
                first_q[i] <= first_q[i-1];
                last_q[i]  <= last_q[i-1];
                prod_q[i]  <= prod_q[i-1];
            end
        end
    end

    assign p_ext = ACC_WIDTH'(prod_q[MULT_LATENCY-1]);
    assign sum   = first_q[MULT_LATENCY-1] ? p_ext : acc_q + p_ext;

    always_comb begin
        acc_d       = acc_q;
        out_data_d  = out_data_q;
        out_valid_d = 1'b0;
        if (vld_q[MULT_LATENCY-1]) begin
            acc_d = sum;
            if (last_q[MULT_LATENCY-1]) begin
                out_data_d  = sum;
                out_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = (band_cnt_q != '0) || (|vld_q);

endmodule

// File: tb/tb_stream_dot_accumulator.sv
// Directed bench: default-parameter instance plus a NUM_BANDS=1, MULT_LATENCY=1 instance.
module tb_stream_dot_accumulator;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic               v1 = 1'b0, v2 = 1'b0;
    logic signed [15:0] a1 = '0, b1 = '0, a2 = '0, b2 = '0;
    logic               ov1, ov2, busy1, busy2;
    logic signed [47:0] od1, od2;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int t_last   = 0;

    int     q1_cyc[$], q2_cyc[$];
    longint q1_dat[$], q2_dat[$];
    logic   q1_busy[$];

    stream_dot_accumulator #(
        .DATA_WIDTH(16), .ACC_WIDTH(48), .NUM_BANDS(8), .MULT_LATENCY(2)
    ) u_dut (
        .clk(clk), .rst(rst), .in_valid(v1), .in_a(a1), .in_b(b1),
        .out_valid(ov1), .out_data(od1), .busy(busy1)
    );

    stream_dot_accumulator #(
        .DATA_WIDTH(16), .ACC_WIDTH(48), .NUM_BANDS(1), .MULT_LATENCY(1)
    ) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(v2), .in_a(a2), .in_b(b2),
        .out_valid(ov2), .out_data(od2), .busy(busy2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (ov1) begin
            q1_cyc.push_back(cyc);
            q1_dat.push_back(od1);
            q1_busy.push_back(busy1);
        end
        if (ov2) begin
            q2_cyc.push_back(cyc);
            q2_dat.push_back(od2);
        end
    end

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send1(input logic signed [15:0] a, input logic signed [15:0] b);
        v1 = 1'b1; a1 = a; b1 = b;
        @(posedge clk); #1;
        v1 = 1'b0;
        t_last = cyc;
    endtask

    task automatic send2(input logic signed [15:0] a, input logic signed [15:0] b);
        v2 = 1'b1; a2 = a; b2 = b;
        @(posedge clk); #1;
        v2 = 1'b0;
        t_last = cyc;
    endtask

    task automatic clear_q;
        q1_cyc.delete(); q1_dat.delete(); q1_busy.delete();
        q2_cyc.delete(); q2_dat.delete();
    endtask

    // Expects exactly one pulse from the default instance, MULT_LATENCY posedges after the last pair.
    task automatic expect_single(input string tag, input longint exp, input int last_cyc);
        check({tag, "_npulse"}, q1_cyc.size(), 1);
        if (q1_cyc.size() >= 1) begin
            check({tag, "_lat"}, q1_cyc[0] - last_cyc, 2);
            check({tag, "_data"}, q1_dat[0], exp);
        end
    endtask

    int t_a, t_b, t_c;

    initial begin
        // Reset state
        idle(2);
        rst = 1'b0;
        check("rst_out_valid", ov1, 0);
        check("rst_out_data", od1, 0);
        check("rst_busy", busy1, 0);
        check("rst_out_valid_nb1", ov2, 0);

        // 8 x (1,1)
        clear_q();
        send1(1, 1);
        check("t1_busy_partial", busy1, 1);
        for (int i = 1; i < 8; i++) send1(1, 1);
        t_a = t_last;
        idle(6);
        expect_single("t1", 8, t_a);
        if (q1_busy.size() >= 1) check("t1_busy_at_pulse", q1_busy[0], 0);
        check("t1_busy_after", busy1, 0);
        check("t1_hold", od1, 8);

        // a=1..8, b=2 with gaps of 1-3 idle cycles
        clear_q();
        for (int i = 1; i <= 8; i++) begin
            send1(16'(i), 2);
            if (i < 8 && (i % 2) == 1) begin
                idle((i % 3) + 1);
                if (i == 3) check("t2_busy_in_gap", busy1, 1);
            end
        end
        t_a = t_last;
        idle(6);
        expect_single("t2", 72, t_a);

        // Extreme operands
        clear_q();
        for (int i = 0; i < 8; i++) send1(-16'sd32768, -16'sd32768);
        t_a = t_last;
        idle(5);
        expect_single("t3a", 64'sd8589934592, t_a);
        clear_q();
        for (int i = 0; i < 8; i++) send1(-16'sd32768, 16'sd32767);
        t_a = t_last;
        idle(5);
        expect_single("t3b", -64'sd8589672448, t_a);

        // Three back-to-back vectors
        clear_q();
        for (int i = 0; i < 8; i++) send1(1, 1);
        t_a = t_last;
        for (int i = 0; i < 8; i++) send1(2, 1);
        t_b = t_last;
        for (int i = 0; i < 8; i++) send1(-3, 1);
        t_c = t_last;
        idle(6);
        check("t4_npulse", q1_cyc.size(), 3);
        if (q1_cyc.size() == 3) begin
            check("t4_lat0", q1_cyc[0] - t_a, 2);
            check("t4_gap01", q1_cyc[1] - q1_cyc[0], 8);
            check("t4_gap12", q1_cyc[2] - q1_cyc[1], 8);
            check("t4_d0", q1_dat[0], 8);
            check("t4_d1", q1_dat[1], 16);
            check("t4_d2", q1_dat[2], -24);
            check("t4_lat2", q1_cyc[2] - t_c, 2);
        end
        check("t4_tb", t_b - t_a, 8);

        // Partial vector discarded by mid-vector reset
        clear_q();
        for (int i = 0; i < 5; i++) send1(1, 1);
        rst = 1'b1; v1 = 1'b1; a1 = 7; b1 = 7;
        @(posedge clk); #1;
        rst = 1'b0; v1 = 1'b0;
        check("t5_busy_after_rst", busy1, 0);
        check("t5_out_data_rst", od1, 0);
        check("t5_out_valid_rst", ov1, 0);
        idle(5);
        check("t5_no_partial_pulse", q1_cyc.size(), 0);
        for (int i = 0; i < 8; i++) send1(1, 1);
        t_a = t_last;
        idle(5);
        expect_single("t5", 8, t_a);

        // NUM_BANDS=1, MULT_LATENCY=1, continuous
        clear_q();
        send2(3, 4);
        t_a = t_last;
        send2(-2, 5);
        send2(0, 7);
        idle(4);
        check("t6_npulse", q2_cyc.size(), 3);
        if (q2_cyc.size() == 3) begin
            check("t6_lat0", q2_cyc[0] - t_a, 1);
            check("t6_gap01", q2_cyc[1] - q2_cyc[0], 1);
            check("t6_gap12", q2_cyc[2] - q2_cyc[1], 1);
            check("t6_d0", q2_dat[0], 12);
            check("t6_d1", q2_dat[1], -10);
            check("t6_d2", q2_dat[2], 0);
        end
        check("t6_idle_valid", ov2, 0);
        check("t6_idle_busy", busy2, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/stream_dot_accumulator.md
# stream_dot_accumulator

Streaming signed multiply-accumulate stage for the LCMV filter datapath. It consumes one band sample pair (pixel value, filter coefficient) per valid cycle and emits one dot-product result per pixel after NUM_BANDS accepted pairs. It sits directly downstream of the register delay lines that align pixel and coefficient streams, and feeds the class-score comparison stage. The multiply pipeline uses the same reset-to-zero delay-line behaviour internally for its control tags.

## Interface
- DATA_WIDTH, 16: width of each signed operand.
- ACC_WIDTH, 48: width of the signed accumulator and result. Must be ≥ 2*DATA_WIDTH + $clog2(NUM_BANDS); elaboration fails otherwise.
- NUM_BANDS, 8: accepted pairs per dot product. Must be ≥ 1.
- MULT_LATENCY, 2: product pipeline depth in cycles. Must be ≥ 1.

Ports:
- clk  in  1  clock; all logic is posedge.
- rst  in  1  reset: synchronous, active-high.
- in_valid  in  1  operand pair present this cycle.
- in_a  in  DATA_WIDTH  signed pixel sample.
- in_b  in  DATA_WIDTH  signed coefficient.
- out_valid  out  1  one-cycle pulse: out_data holds a completed dot product.
- out_data  out  ACC_WIDTH  signed dot product. Holds its value between pulses.
- busy  out  1  high while a vector is partially accepted or products are in flight.

## Operation
- There is no backpressure. Every cycle with in_valid=1 accepts a pair. Gaps of any length between pairs are allowed.
- Band counter band_cnt (width $clog2(NUM_BANDS), min 1) counts accepted pairs.
  - It resets to 0 and increments on each accepted pair.
  - It wraps from NUM_BANDS-1 to 0.
  - first = (band_cnt==0); last = (band_cnt==NUM_BANDS-1). With NUM_BANDS=1, every pair is both first and last.
- Product path:
  - The product is the full signed in_a*in_b (2*DATA_WIDTH bits), sign-extended to ACC_WIDTH.
  - The product travels through MULT_LATENCY registers.
  - valid, first and last tags travel in parallel delay registers that reset to 0.
- Accumulator stage, acting on a tagged product p with valid tag set:
  - first: acc ← p.
  - otherwise: acc ← acc + p.
  - last: out_data ← (first ? p : acc + p) and out_valid ← 1 for one cycle.
- Arithmetic is two's complement modulo 2^ACC_WIDTH. There is no saturation; the parameter rule guarantees no overflow.
- busy = (band_cnt≠0) OR any valid tag in the product pipeline is set.
- Reset, including mid-vector: band_cnt, acc, every pipeline tag and product register, out_valid and out_data all clear to 0. Any partial vector is discarded. The next accepted pair is band 0.
- In-flight products keep advancing regardless of in_valid. A new vector may start the cycle after the previous last pair is accepted.

## Timing
- Reset values: out_valid=0, out_data=0, busy=0.
- Latency: if the last pair of a vector is accepted at cycle T (sampled at posedge T), out_valid=1 during cycle T+MULT_LATENCY+1.
  - Default parameters give 3 cycles.
  - Latency is independent of gaps earlier in the vector.
- Throughput is one pair per cycle sustained. Back-to-back vectors produce out_valid pulses exactly NUM_BANDS cycles apart.
- out_valid never stays high for two consecutive cycles when NUM_BANDS>1. With NUM_BANDS=1 and continuous input, it is high every cycle.
- A product tagged first overwrites acc in the same cycle that the previous vector's last product would have been summed. There is no conflict, because tags are exclusive per product.
- rst asserted at posedge T: outputs are 0 in cycle T+1. in_valid at that posedge is ignored.

## Test plan
- Defaults; 8 consecutive pairs a=1, b=1 → single out_valid pulse 3 cycles after the 8th pair, out_data=8, busy falls the same cycle.
- Defaults; pairs a=1..8, b=2 with 1–3 idle cycles between random pairs → out_data=72, pulse 3 cycles after the last pair.
- Defaults; 8 pairs a=-32768, b=-32768 → out_data=8589934592. Then 8 pairs a=-32768, b=32767 → out_data=-8589672448.
- Defaults; three back-to-back vectors (all b=1; a=1, a=2, a=-3) → pulses 8 cycles apart with out_data 8, 16, -24; no pulse merges.
- Defaults; 5 pairs a=b=1, rst for 1 cycle, then 8 pairs a=b=1 → no pulse from the partial vector, out_data=8 afterwards, busy=0 right after reset.
- NUM_BANDS=1, MULT_LATENCY=1; continuous pairs (3,4), (-2,5), (0,7) → out_valid high 2 cycles after each, out_data 12, -10, 0.
